oam_dma_bus: RTL and testbench
==============================

OAM_DMA_BUS -- requirements
Module: oam_dma_bus

Interface
REQ-001 Parameter DMA_LEN, default 160, bytes per transfer.
REQ-002 Parameter OAM_BASE, default 16'hFE00, destination base address.
REQ-003 clk  input  1  the only clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 cpu_r_addr  input  16 (addr_t)  core read address.
REQ-006 cpu_w_addr  input  16 (addr_t)  core write address.
REQ-007 cpu_w_data  input  8 (data_t)  core write data.
REQ-008 cpu_w_wen  input  1  core write strobe.
REQ-009 cpu_r_data  output  8 (data_t)  read data to the core, valid one cycle after cpu_r_addr.
REQ-010 mem_r_addr  output  16  memory read address.
REQ-011 mem_w_addr  output  16  memory write address.
REQ-012 mem_w_data  output  8  memory write data.
REQ-013 mem_w_wen  output  1  memory write strobe.
REQ-014 mem_r_data  input  8  memory read data, synchronous, valid one cycle after mem_r_addr.
REQ-015 dma_active  output  1  high while DMA owns the memory port.

Function
REQ-016 The block sits between the core bus and memory, and owns the DMA register at 16'hFF46 and HRAM at 16'hFF80-16'hFFFE.
REQ-017 In IDLE and START, cpu_r_addr, cpu_w_addr, cpu_w_data and cpu_w_wen pass combinationally to mem_*, except for accesses to FF46 or HRAM.
REQ-018 A core write to FF46 latches cpu_w_data as the source page and is never forwarded to memory (mem_w_wen=0 that cycle).
REQ-019 Source page 8'hE0-8'hFF maps to page minus 8'h20; pages 8'h00-8'hDF are used unchanged.
REQ-020 A read of FF46 returns the latched page, with the same one-cycle latency as memory reads.
REQ-021 HRAM is internal, with 1-cycle registered reads and writes; it is accessible to the core in every state, and HRAM accesses are never forwarded to memory.
REQ-022 cpu_r_data selects among memory, HRAM, FF46 and 8'hFF, using a select registered from the previous cycle's cpu_r_addr.
REQ-023 FSM states are IDLE, START, XFER and LAST; reset state is IDLE.
REQ-024 IDLE -> START on the cycle after a FF46 write; START lasts exactly 1 cycle and then goes to XFER with index i=0.
REQ-025 In XFER cycle i (0..DMA_LEN-1): mem_r_addr={page,i[7:0]}; if i>0, then mem_w_addr=OAM_BASE+i-1, mem_w_data=mem_r_data and mem_w_wen=1.
REQ-026 XFER -> LAST after i=DMA_LEN-1; LAST writes byte DMA_LEN-1 to OAM_BASE+DMA_LEN-1; LAST -> IDLE.
REQ-027 A FF46 write at cycle 0 produces OAM writes at cycles 3..DMA_LEN+2; IDLE is re-entered at cycle DMA_LEN+3.
REQ-028 dma_active=1 exactly in XFER and LAST.
REQ-029 While dma_active, core reads outside HRAM and FF46 return 8'hFF, and core writes outside HRAM and FF46 are dropped.
REQ-030 A FF46 write during START, XFER or LAST relatches the page and moves to START; the in-flight byte is discarded (no write in the following cycle).
REQ-031 The index counter is 8 bits and never wraps; DMA_LEN values up to 256 are legal.

Reset
REQ-032 On rst: state=IDLE, i=0, page=8'h00, dma_active=0, mem_w_wen=0, cpu_r_data select=memory.
REQ-033 rst asserted mid-transfer aborts the transfer; no mem write occurs in the cycle after reset.
REQ-034 HRAM contents are not reset.

Structure
REQ-035 sm83_pkg gains dma_state_t, DMA_REG_ADDR=16'hFF46, HRAM_BASE=16'hFF80 and HRAM_END=16'hFFFE; addr_t and data_t are reused.
REQ-036 HRAM is one sub-module, hram (127x8, synchronous read/write); the FSM, muxing and counter live in oam_dma_bus.

Verification
REQ-037 The bench covers: memory C000-C09F = i^8'h5A; write FF46=8'hC0 at cycle 0 -> FE00+i=i^8'h5A for all i, dma_active high on cycles 2-162, IDLE at cycle 163.
REQ-038 The bench covers: during DMA, write FF90=8'h3C and then read FF90 -> 8'h3C; read C000 -> 8'hFF; write D000=8'h11 -> no mem_w_wen for D000.
REQ-039 The bench covers: FF46=8'hE1 -> reads are issued from E100 remapped to C100..C19F.
REQ-040 The bench covers: FF46=8'hC0, then FF46=8'hC1 at XFER i=50 -> no write in the next cycle, restart from C100, final FE00-FE9F matches page C1.
REQ-041 The bench covers: rst at XFER i=80 -> mem_w_wen=0 in the next cycle, dma_active=0, FF46 reads 8'h00.
REQ-042 The bench covers: IDLE, read FF46 after a write of 8'h80 -> 8'h80 one cycle after the address; no memory write was issued for FF46.

Source files
------------

// File: rtl/sm83_pkg.sv
// sm83_pkg: shared types and address map for the SM83 bus fabric.
// Holds the core bus types, the OAM DMA state encoding, the read-data
// source select, the fixed register/HRAM addresses and two small helpers
// used by the DMA bus block.
package sm83_pkg;

   typedef logic [15:0] addr_t;
   typedef logic [7:0]  data_t;

   typedef enum logic [1:0] {
      DMA_IDLE  = 2'd0,
      DMA_START = 2'd1,
      DMA_XFER  = 2'd2,
      DMA_LAST  = 2'd3
   } dma_state_t;

   // Source of cpu_r_data, chosen one cycle ahead of the data.
   typedef enum logic [1:0] {
      RSEL_MEM  = 2'd0,
      RSEL_HRAM = 2'd1,
      RSEL_REG  = 2'd2,
      RSEL_FF   = 2'd3
   } rd_sel_t;

   localparam addr_t DMA_REG_ADDR = 16'hFF46;
   localparam addr_t HRAM_BASE    = 16'hFF80;
   localparam addr_t HRAM_END     = 16'hFFFE;

   function automatic logic is_hram(input addr_t a);
      return (a >= HRAM_BASE) && (a <= HRAM_END);
   endfunction

   // Pages E0-FF are echo space; fetch from the underlying page 0x20 lower.
   function automatic data_t dma_src_page(input data_t p);
      return (p >= 8'hE0) ? (p - 8'h20) : p;
   endfunction

endpackage

// File: rtl/oam_dma_bus_hram.sv
// hram: 127 x 8 high RAM (FF80-FFFE) with registered read and write.
// Ports:
//   clk     - clock
//   r_en    - read enable; r_data updates only when set
//   r_idx   - read index (address - FF80)
//   w_en    - write enable
//   w_idx   - write index (address - FF80)
//   w_data  - write data
//   r_data  - read data, valid the cycle after r_idx
// Contents are deliberately not reset.
import sm83_pkg::*;

module hram (
   input  logic       clk,
   input  logic       r_en,
   input  logic [6:0] r_idx,
   input  logic       w_en,
   input  logic [6:0] w_idx,
   input  data_t      w_data,
   output data_t      r_data
);

   data_t mem [0:126];

   // Read-before-write on a same-cycle collision at one index.
   always_ff @(posedge clk) begin
      if (w_en) begin
         mem[w_idx] <= w_data;
      end
      if (r_en) begin
         r_data <= mem[r_idx];
      end
   end

endmodule

// File: rtl/oam_dma_bus.sv
// oam_dma_bus: sits between the core bus and memory, owns the DMA register
// (FF46) and HRAM, and runs the OAM DMA engine that copies DMA_LEN bytes
// from page {src,00} to OAM_BASE.
// Ports:
//   clk, rst                  - clock, synchronous active-high reset
//   cpu_r_addr                - core read address
//   cpu_w_addr/data/wen       - core write port
//   cpu_r_data                - core read data, one cycle after cpu_r_addr
//   mem_r_addr                - memory read address
//   mem_w_addr/data/wen       - memory write port
//   mem_r_data                - memory read data, one cycle after mem_r_addr
//   dma_active                - high while the DMA owns the memory port
import sm83_pkg::*;

module oam_dma_bus #(
   parameter int    DMA_LEN  = 160,
   parameter addr_t OAM_BASE = 16'hFE00
) (
   input  logic  clk,
   input  logic  rst,
   input  addr_t cpu_r_addr,
   input  addr_t cpu_w_addr,
   input  data_t cpu_w_data,
   input  logic  cpu_w_wen,
   output data_t cpu_r_data,
   output addr_t mem_r_addr,
   output addr_t mem_w_addr,
   output data_t mem_w_data,
   output logic  mem_w_wen,
   input  data_t mem_r_data,
   output logic  dma_active
);

   localparam logic [7:0] LAST_IDX = 8'(DMA_LEN - 1);

   dma_state_t state, state_next;
   logic [7:0] idx, idx_next;
   data_t      page;
   rd_sel_t    rd_sel, rd_sel_next;
   data_t      hram_data;

   logic reg_wr, hram_wr, hram_rd;

   assign reg_wr  = cpu_w_wen && (cpu_w_addr == DMA_REG_ADDR);
   assign hram_wr = cpu_w_wen && is_hram(cpu_w_addr);
   assign hram_rd = is_hram(cpu_r_addr);

   hram u_hram (
      .clk    (clk),
      .r_en   (hram_rd),
      .r_idx  (cpu_r_addr[6:0]),
      .w_en   (hram_wr),
      .w_idx  (cpu_w_addr[6:0]),
      .w_data (cpu_w_data),
      .r_data (hram_data)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= DMA_IDLE;
         idx    <= 8'h00;
         page   <= 8'h00;
         rd_sel <= RSEL_MEM;
      end else begin
         state  <= state_next;
         idx    <= idx_next;
         rd_sel <= rd_sel_next;
         if (reg_wr) begin
            page <= cpu_w_data;
         end
      end
   end

   // Next state. idx stops at LAST_IDX, so it never wraps even for 256.
   always_comb begin
      state_next = state;
      idx_next   = idx;
      case (state)
         DMA_IDLE:  state_next = DMA_IDLE;
         DMA_START: begin
            state_next = DMA_XFER;
            idx_next   = 8'h00;
         end
         DMA_XFER: begin
            if (idx == LAST_IDX) begin
               state_next = DMA_LAST;
            end else begin
               idx_next = idx + 8'd1;
            end
         end
         DMA_LAST:  state_next = DMA_IDLE;
         default:   state_next = DMA_IDLE;
      endcase
      // A register write always (re)starts, dropping the in-flight byte.
      if (reg_wr) begin
         state_next = DMA_START;
      end
   end

   // Memory port: pass-through from the core unless the DMA owns it. The
   // DMA write in cycle i stores the byte read in cycle i-1, so it trails
   // the read address by one.
   always_comb begin
      dma_active = (state == DMA_XFER) || (state == DMA_LAST);
      mem_r_addr = cpu_r_addr;
      mem_w_addr = cpu_w_addr;
      mem_w_data = cpu_w_data;
      mem_w_wen  = cpu_w_wen && !reg_wr && !hram_wr;
      if (dma_active) begin
         mem_r_addr = {dma_src_page(page), idx};
         mem_w_data = mem_r_data;
         if (state == DMA_LAST) begin
            mem_w_addr = OAM_BASE + {8'h00, idx};
            mem_w_wen  = 1'b1;
         end else begin
            mem_w_addr = OAM_BASE + {8'h00, idx} - 16'd1;
            mem_w_wen  = (idx != 8'h00);
         end
      end
   end

   always_comb begin
      rd_sel_next = RSEL_MEM;
      if (cpu_r_addr == DMA_REG_ADDR) begin
         rd_sel_next = RSEL_REG;
      end else if (hram_rd) begin
         rd_sel_next = RSEL_HRAM;
      end else if (dma_active) begin
         rd_sel_next = RSEL_FF;
      end
   end

   always_comb begin
      cpu_r_data = mem_r_data;
      case (rd_sel)
         RSEL_MEM:  cpu_r_data = mem_r_data;
         RSEL_HRAM: cpu_r_data = hram_data;
         RSEL_REG:  cpu_r_data = page;
         RSEL_FF:   cpu_r_data = 8'hFF;
         default:   cpu_r_data = mem_r_data;
      endcase
   end

endmodule

// File: tb/tb_oam_dma_bus.sv
// tb_oam_dma_bus: bench for oam_dma_bus. A flat 64 KiB memory sits on the
// mem_* port. A per-cycle monitor predicts every output from a schedule
// model: a DMA started by an FF46 write at cycle t reads byte k at t+2+k,
// writes byte k to OAM at t+3+k and is finished after t+DMA_LEN+2.
import sm83_pkg::*;

module tb_oam_dma_bus;

   localparam int    DMA_LEN  = 160;
   localparam addr_t OAM_BASE = 16'hFE00;

   logic  clk = 1'b0;
   logic  rst;
   addr_t cpu_r_addr, cpu_w_addr;
   data_t cpu_w_data;
   logic  cpu_w_wen;
   data_t cpu_r_data;
   addr_t mem_r_addr, mem_w_addr;
   data_t mem_w_data;
   logic  mem_w_wen;
   data_t mem_r_data;
   logic  dma_active;

   always #5 clk = ~clk;

   oam_dma_bus #(.DMA_LEN(DMA_LEN), .OAM_BASE(OAM_BASE)) dut (
      .clk        (clk),
      .rst        (rst),
      .cpu_r_addr (cpu_r_addr),
      .cpu_w_addr (cpu_w_addr),
      .cpu_w_data (cpu_w_data),
      .cpu_w_wen  (cpu_w_wen),
      .cpu_r_data (cpu_r_data),
      .mem_r_addr (mem_r_addr),
      .mem_w_addr (mem_w_addr),
      .mem_w_data (mem_w_data),
      .mem_w_wen  (mem_w_wen),
      .mem_r_data (mem_r_data),
      .dma_active (dma_active)
   );

   // ---------------- environment memory ----------------
   data_t mem_model [0:65535];

   always @(posedge clk) begin
      if (mem_w_wen === 1'b1) mem_model[mem_w_addr] <= mem_w_data;
      mem_r_data <= mem_model[mem_r_addr];
   end

   // ---------------- checking ----------------
   int n_pass  = 0;
   int n_total = 0;
   int cyc     = 0;

   task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
   endtask

   function automatic bit plain_addr(input addr_t a);
      return (a != 16'hFF46) && !((a >= 16'hFF80) && (a <= 16'hFFFE));
   endfunction

   function automatic bit hram_addr(input addr_t a);
      return (a >= 16'hFF80) && (a <= 16'hFFFE);
   endfunction

   // ---------------- reference model + monitor ----------------
   bit    mon_en = 0;
   bit    sched_ok = 0;
   int    t0 = 0;
   data_t page_ref = 8'h00;
   data_t src_pg = 8'h00;
   data_t hram_ref [0:126];
   bit    hram_vld [0:126];
   bit    rd_exp_ok = 0;
   data_t rd_exp = 8'h00;

   always @(negedge clk) begin : mon
      int    d;
      bit    exp_act, exp_wen, rd_is_reg;
      addr_t exp_wa;
      data_t exp_wd;
      d = sched_ok ? (cyc - t0) : -1;
      exp_act = sched_ok && (d >= 2) && (d <= DMA_LEN + 2);
      if (exp_act) begin
         exp_wen = (d >= 3);
         exp_wa  = OAM_BASE + 16'(d - 3);
         exp_wd  = (d >= 3) ? mem_model[{src_pg, 8'(d - 3)}] : 8'h00;
      end else begin
         exp_wen = cpu_w_wen && plain_addr(cpu_w_addr);
         exp_wa  = cpu_w_addr;
         exp_wd  = cpu_w_data;
      end
      if (mon_en) begin
         check_eq("dma_active", {15'h0, dma_active}, {15'h0, exp_act});
         check_eq("mem_w_wen", {15'h0, mem_w_wen}, {15'h0, exp_wen});
         if (exp_wen) begin
            check_eq("mem_w_addr", mem_w_addr, exp_wa);
            check_eq("mem_w_data", {8'h0, mem_w_data}, {8'h0, exp_wd});
         end
         if (exp_act && d <= DMA_LEN + 1)
            check_eq("dma_r_addr", mem_r_addr, {src_pg, 8'(d - 2)});
         else if (!exp_act && plain_addr(cpu_r_addr))
            check_eq("pass_r_addr", mem_r_addr, cpu_r_addr);
         if (rd_exp_ok)
            check_eq("cpu_r_data", {8'h0, cpu_r_data}, {8'h0, rd_exp});
      end
      // Read expectation for next cycle (memory/HRAM values before this
      // cycle's writes land).
      rd_is_reg = 0;
      rd_exp_ok = 1;
      if (rst) begin
         rd_exp_ok = !exp_act;
         rd_exp    = mem_model[cpu_r_addr];
      end else if (cpu_r_addr == 16'hFF46) begin
         rd_is_reg = 1;
      end else if (hram_addr(cpu_r_addr)) begin
         rd_exp_ok = hram_vld[7'(cpu_r_addr - 16'hFF80)];
         rd_exp    = hram_ref[7'(cpu_r_addr - 16'hFF80)];
      end else if (exp_act) begin
         rd_exp = 8'hFF;
      end else begin
         rd_exp = mem_model[cpu_r_addr];
      end
      // State update at the end of the cycle.
      if (cpu_w_wen && hram_addr(cpu_w_addr)) begin
         hram_ref[7'(cpu_w_addr - 16'hFF80)] = cpu_w_data;
         hram_vld[7'(cpu_w_addr - 16'hFF80)] = 1;
      end
      if (rst) begin
         sched_ok = 0;
         page_ref = 8'h00;
      end else if (cpu_w_wen && cpu_w_addr == 16'hFF46) begin
         sched_ok = 1;
         t0       = cyc;
         page_ref = cpu_w_data;
         src_pg   = (cpu_w_data >= 8'hE0) ? cpu_w_data - 8'h20 : cpu_w_data;
      end else if (sched_ok && d >= DMA_LEN + 2) begin
         sched_ok = 0;
      end
      if (rd_is_reg) rd_exp = page_ref;
      cyc++;
   end

   // ---------------- driver tasks ----------------
   task automatic bus(input addr_t ra, input addr_t wa, input data_t wd, input logic we);
      cpu_r_addr = ra;
      cpu_w_addr = wa;
      cpu_w_data = wd;
      cpu_w_wen  = we;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) bus(16'h0000, 16'h0000, 8'h00, 1'b0);
   endtask

   data_t exp_q [$];

   task automatic snap_page(input data_t pg);
      exp_q.delete();
      for (int k = 0; k < DMA_LEN; k++) exp_q.push_back(mem_model[{pg, 8'(k)}]);
   endtask

   task automatic check_oam(input string tag);
      for (int k = 0; k < DMA_LEN; k++) begin
         if (exp_q.size() == 0) begin
            check_eq({tag, "_qempty"}, 16'd1, 16'd0);
            break;
         end
         check_eq(tag, {8'h0, mem_model[OAM_BASE + 16'(k)]}, {8'h0, exp_q.pop_front()});
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      data_t d000_before;
      int    op;
      addr_t a;
      for (int k = 0; k < 65536; k++) mem_model[k] <= 8'($urandom);
      for (int k = 0; k < DMA_LEN; k++) mem_model[16'hC000 + k] <= 8'(k) ^ 8'h5A;
      rst = 1'b1;
      idle(3);
      rst = 1'b0;
      mon_en = 1;
      // Reset value of the page register.
      bus(16'hFF46, 16'h0000, 8'h00, 1'b0);
      idle(1);

      // Fill HRAM, then read it all back.
      for (int k = 0; k < 127; k++) bus(16'h0000, 16'hFF80 + 16'(k), 8'($urandom), 1'b1);
      for (int k = 0; k < 127; k++) bus(16'hFF80 + 16'(k), 16'h0000, 8'h00, 1'b0);
      idle(1);

      // Basic transfer from page C0 (bytes i^5A).
      exp_q.delete();
      for (int k = 0; k < DMA_LEN; k++) exp_q.push_back(8'(k) ^ 8'h5A);
      bus(16'h0000, 16'hFF46, 8'hC0, 1'b1);
      idle(DMA_LEN + 3);
      check_oam("oam_c0");

      // Core traffic during DMA: HRAM works, memory is blocked.
      d000_before = mem_model[16'hD000];
      bus(16'h0000, 16'hFF46, 8'hC0, 1'b1);
      idle(9);
      bus(16'h0000, 16'hFF90, 8'h3C, 1'b1);
      bus(16'hFF90, 16'h0000, 8'h00, 1'b0);
      bus(16'hC000, 16'h0000, 8'h00, 1'b0);
      bus(16'h0000, 16'hD000, 8'h11, 1'b1);
      idle(DMA_LEN);
      check_eq("hram_ff90", {8'h0, hram_ref[7'h10]}, 16'h003C);
      check_eq("d000_kept", {8'h0, mem_model[16'hD000]}, {8'h0, d000_before});

      // Echo page E1 fetches from C1.
      snap_page(8'hC1);
      bus(16'h0000, 16'hFF46, 8'hE1, 1'b1);
      idle(DMA_LEN + 3);
      check_oam("oam_e1");

      // Restart at i=50 with page C1.
      for (int k = 0; k < DMA_LEN; k++) mem_model[16'hC100 + k] <= 8'($urandom);
      #1;
      snap_page(8'hC1);
      bus(16'h0000, 16'hFF46, 8'hC0, 1'b1);
      idle(51);
      bus(16'h0000, 16'hFF46, 8'hC1, 1'b1);
      idle(DMA_LEN + 3);
      check_oam("oam_restart");

      // Reset at i=80.
      bus(16'h0000, 16'hFF46, 8'hC0, 1'b1);
      idle(81);
      rst = 1'b1;
      idle(1);
      rst = 1'b0;
      bus(16'hFF46, 16'h0000, 8'h00, 1'b0);
      idle(2);

      // Page register readback; the write starts a DMA from page 80.
      snap_page(8'h80);
      bus(16'h0000, 16'hFF46, 8'h80, 1'b1);
      bus(16'hFF46, 16'h0000, 8'h00, 1'b0);
      idle(DMA_LEN + 2);
      check_oam("oam_80");

      // Random traffic.
      for (int n = 0; n < 2500; n++) begin
         op = $urandom_range(0, 99);
         if (op < 2) bus(16'h0000, 16'hFF46, 8'($urandom), 1'b1);
         else if (op < 25) bus(16'h0000, 16'hFF80 + 16'($urandom_range(0, 126)), 8'($urandom), 1'b1);
         else if (op < 45) bus(16'h0000, 16'($urandom), 8'($urandom), 1'b1);
         else begin
            op = $urandom_range(0, 99);
            if (op < 40) a = 16'hFF80 + 16'($urandom_range(0, 126));
            else if (op < 50) a = 16'hFF46;
            else a = 16'($urandom);
            bus(a, 16'h0000, 8'h00, 1'b0);
         end
      end
      idle(DMA_LEN + 5);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
